// File: rtl/video_timing_recovery.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_recovery
//  Description : Recovers line/frame timing from a 1-bit DE-qualified video
//                stream sampled on a pixel-rate clock enable. Produces pixel
//                coordinates, start-of-frame, lock status, violation pulses
//                and the measured line width / frame height.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_timing_recovery #(
   parameter logic [9:0] NumColTotal  = 10'd800,
   parameter logic [9:0] NumColActive = 10'd640,
   parameter logic [9:0] NumRowActive = 10'd480
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ce_i,
   input  logic       de_i,
   input  logic       pix_i,
   output logic       pix_valid_o,
   output logic       pix_o,
   output logic [9:0] col_o,
   output logic [9:0] row_o,
   output logic       sof_o,
   output logic       locked_o,
   output logic       err_o,
   output logic [9:0] width_o,
   output logic [9:0] height_o
);

   localparam logic [9:0] c_CNT_MAX = 10'd1023;

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   state_t     r_state;
   logic [9:0] r_col_cnt;
   logic [9:0] r_row_cnt;
   logic [9:0] r_gap_cnt;
   logic       r_de_prev;

   logic       w_active;
   logic       w_line_start;
   logic       w_line_end;
   logic       w_frame_gap;
   logic       w_tracking;
   logic       w_viol;
   logic [9:0] w_col_inc;
   logic [9:0] w_row_inc;

   // Classify the current sample and gather every timing violation it carries
   always_comb begin
      w_active     = ce_i & de_i;
      w_line_start = w_active & ~r_de_prev;
      w_line_end   = ce_i & ~de_i & r_de_prev;
      // The gap counter can only reach NumColTotal-1 after that many low
      // samples, so a line end and a frame gap never share one sample.
      w_frame_gap  = ce_i & ~de_i & (r_gap_cnt == (NumColTotal - 10'd1));
      w_tracking   = (r_state != ST_SEARCH);
      w_col_inc    = (r_col_cnt == c_CNT_MAX) ? c_CNT_MAX : (r_col_cnt + 10'd1);
      w_row_inc    = (r_row_cnt == c_CNT_MAX) ? c_CNT_MAX : (r_row_cnt + 10'd1);
      // Column counter restarts at 0 every line, so equality with the active
      // width marks the first overlong pixel exactly once per line.
      w_viol       = (w_active     & (r_col_cnt == NumColActive))
                   | (w_line_start & (r_row_cnt >= NumRowActive))
                   | (w_line_end   & (r_col_cnt != NumColActive))
                   | (w_frame_gap  & (r_row_cnt != NumRowActive));
   end

   // Track line/frame position, capture measured sizes and drive pixel outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_col_cnt   <= '0;
         r_row_cnt   <= '0;
         r_gap_cnt   <= '0;
         r_de_prev   <= 1'b0;
         pix_valid_o <= 1'b0;
         pix_o       <= 1'b0;
         col_o       <= '0;
         row_o       <= '0;
         sof_o       <= 1'b0;
         width_o     <= '0;
         height_o    <= '0;
      end else begin
         pix_valid_o <= 1'b0;
         sof_o       <= 1'b0;
         if (ce_i) begin
            r_de_prev <= de_i;
            pix_o     <= pix_i;
            if (de_i) begin
               r_gap_cnt   <= '0;
               r_col_cnt   <= w_col_inc;
               col_o       <= r_col_cnt;
               row_o       <= r_row_cnt;
               pix_valid_o <= w_tracking;
               sof_o       <= w_tracking & (r_col_cnt == 10'd0) & (r_row_cnt == 10'd0);
            end else begin
               if (r_gap_cnt != NumColTotal) begin
                  r_gap_cnt <= r_gap_cnt + 10'd1;
               end
               if (w_frame_gap) begin
                  height_o  <= r_row_cnt;
                  r_row_cnt <= '0;
                  r_col_cnt <= '0;
               end else if (r_de_prev) begin
                  width_o   <= r_col_cnt;
                  r_row_cnt <= w_row_inc;
                  r_col_cnt <= '0;
               end
            end
         end
      end
   end

   // Lock state machine: a violation always wins over a simultaneous frame gap
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= ST_SEARCH;
         locked_o <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         err_o <= w_viol & w_tracking;
         case (r_state)
            ST_SEARCH: begin
               if (w_frame_gap) begin
                  r_state <= ST_ACQUIRE;
               end
            end
            ST_ACQUIRE: begin
               if (w_viol) begin
                  r_state <= ST_SEARCH;
               end else if (w_frame_gap) begin
                  r_state  <= ST_LOCKED;
                  locked_o <= 1'b1;
               end
            end
            ST_LOCKED: begin
               if (w_viol) begin
                  r_state  <= ST_SEARCH;
                  locked_o <= 1'b0;
               end
            end
            default: begin
               r_state  <= ST_SEARCH;
               locked_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
